// File: rtl/free_list_pkg.sv
// free_list_pkg: shared rename types (package rv32i_types): preg_t and register counts.
package rv32i_types;
    localparam int NUM_PREGS = 64;
    localparam int ARCH_REGS = 32;
    typedef logic [5:0] preg_t;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: rename/commit bus to the free list.
//   master (rename+commit): drives deq_req, enq_valid, enq_preg, retire_valid, flush
//   slave  (free_list):     drives deq_preg, empty, free_count, overflow_err
interface free_list_if import rv32i_types::*;;
    logic  deq_req;
    preg_t deq_preg;
    logic  empty;
    logic  enq_valid;
    preg_t enq_preg;
    logic  retire_valid;
    logic  flush;
    preg_t free_count;
    logic  overflow_err;
    modport master(output deq_req, enq_valid, enq_preg, retire_valid, flush,
                   input deq_preg, empty, free_count, overflow_err);
    modport slave(input deq_req, enq_valid, enq_preg, retire_valid, flush,
                  output deq_preg, empty, free_count, overflow_err);
endinterface

// File: rtl/free_list.sv
// free_list: circular free list of physical registers with speculative head, retire head and tail.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : deq_req/deq_preg/empty for rename, enq_valid/enq_preg/retire_valid for commit,
//                 flush on mispredict, free_count and sticky overflow_err status
module free_list import rv32i_types::*; #(
    parameter int NUM_PREGS = rv32i_types::NUM_PREGS,
    parameter int DEPTH     = NUM_PREGS - ARCH_REGS
) (
    input logic        clk,
    input logic        rst,
    free_list_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    preg_t         mem [DEPTH];
    logic [PW-1:0] head, rhead, tail, head_nxt, rhead_nxt;
    logic          deq_ok, ret_ok, enq_nz, full, enq_ok, err, err_set;
    always_comb begin
        deq_ok    = bus.deq_req && !bus.empty && !bus.flush;
        ret_ok    = bus.retire_valid && (rhead != head);
        rhead_nxt = rhead + PW'(ret_ok);
        // flush restores head to the committed point, including this cycle's retire
        head_nxt  = bus.flush ? rhead_nxt : head + PW'(deq_ok);
        enq_nz    = bus.enq_valid && (bus.enq_preg != '0);
        // tail - retire_head counts every register owned by the list, allocated or not
        full      = (tail - rhead) == PW'(DEPTH);
        enq_ok    = enq_nz && !full;
        err_set   = (bus.retire_valid && !ret_ok) || (enq_nz && full);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            rhead <= '0;
            tail  <= PW'(DEPTH);
            err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= preg_t'(ARCH_REGS + i);
        end else begin
            head  <= head_nxt;
            rhead <= rhead_nxt;
            tail  <= tail + PW'(enq_ok);
            err   <= err | err_set;
            if (enq_ok) mem[tail[IW-1:0]] <= bus.enq_preg;
        end
    end
    assign bus.deq_preg     = mem[head[IW-1:0]];
    assign bus.empty        = head == tail;
    assign bus.free_count   = preg_t'(tail - head);
    assign bus.overflow_err = err;
endmodule
